// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and stall/flush controls of hazard_ctrl_unit
interface hazard_ctrl_if;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd_addr;
    logic       ex_branch_taken;
    logic       ex_mdu_valid;
    logic       ex_mdu_is_div;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_bubble;
    logic       id_ex_flush;
    logic       ex_mem_bubble;
    logic       mdu_done;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd_addr,
               ex_branch_taken, ex_mdu_valid, ex_mdu_is_div,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, id_ex_flush,
               ex_mem_bubble, mdu_done
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd_addr,
               ex_branch_taken, ex_mdu_valid, ex_mdu_is_div,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, id_ex_flush,
               ex_mem_bubble, mdu_done
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use, taken-branch and multi-cycle MDU stall/flush sequencing
module hazard_ctrl_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 34
) (
    input  logic clk,
    input  logic rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

    typedef enum logic {RUN, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_cyc;
    logic             run, mdu_go, load_use, lu_stall, mdu_start, mdu_single, busy_hold, busy_done;

    // all decodes are qualified by rst_n so every output drops asynchronously in reset
    assign n_cyc      = bus.ex_mdu_is_div ? DIV_N : MUL_N;
    assign run        = rst_n && state == RUN;
    assign mdu_go     = run && !bus.ex_branch_taken && bus.ex_mdu_valid;
    assign mdu_start  = mdu_go && n_cyc != ONE;
    assign mdu_single = mdu_go && n_cyc == ONE;
    assign load_use   = bus.ex_mem_read && bus.ex_rd_addr != 5'd0 &&
                        ((bus.id_uses_rs1 && bus.id_rs1_addr == bus.ex_rd_addr) ||
                         (bus.id_uses_rs2 && bus.id_rs2_addr == bus.ex_rd_addr));
    assign lu_stall   = run && !bus.ex_branch_taken && !bus.ex_mdu_valid && load_use;
    assign busy_hold  = rst_n && state == BUSY && cnt > ONE;
    assign busy_done  = rst_n && state == BUSY && cnt == ONE;

    assign bus.pc_stall      = mdu_start || busy_hold || lu_stall;
    assign bus.if_id_stall   = mdu_start || busy_hold || lu_stall;
    assign bus.id_ex_stall   = mdu_start || busy_hold;
    assign bus.ex_mem_bubble = mdu_start || busy_hold;
    assign bus.id_ex_bubble  = lu_stall;
    assign bus.if_id_flush   = run && bus.ex_branch_taken;
    assign bus.id_ex_flush   = run && bus.ex_branch_taken;
    assign bus.mdu_done      = mdu_single || busy_done;

    // MDU sequencer: load N-1 on start, count down in BUSY, return to RUN when the last cycle completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (mdu_start) begin
            state <= BUSY;
            cnt   <= n_cyc - ONE;
        end else if (busy_done) begin
            state <= RUN;
        end else if (busy_hold) begin
            cnt <= cnt - ONE;
        end
    end
endmodule
